// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the async FIFO write port.
// One requester at a time is granted for up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          grant_active,
  output logic [ID_WIDTH-1:0]           grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t              state;
  logic [7:0]          beat_cnt;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                found;
  logic [ID_WIDTH-1:0] sel_id;
  logic                gnt_valid;
  logic                xfer;
  logic                burst_end;
  logic [ID_WIDTH-1:0] next_ptr;

  assign grant_active = (state == BURST);

  // Pick the first valid requester starting at the round-robin pointer.
  always_comb begin
    int idx;
    found  = 1'b0;
    sel_id = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        sel_id = ID_WIDTH'(idx);
      end
    end
  end

  // Steer the granted requester onto the FIFO write port.
  always_comb begin
    gnt_valid = 1'b0;
    wr_data   = '0;
    req_ready = '0;
    if (int'(grant_id) < NUM_REQ) begin
      gnt_valid = req_valid[grant_id];
    end
    xfer  = grant_active & gnt_valid & ~full;
    wr_en = xfer;
    if (grant_active && int'(grant_id) < NUM_REQ) begin
      wr_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (int'(grant_id) == i);
    end
    burst_end = grant_active &
                ((xfer & (beat_cnt == LAST_BEAT)) | ~gnt_valid);
    next_ptr  = ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
  end

  // Grant FSM: IDLE arbitrates, BURST counts beats until limit or drop.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id <= sel_id;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, burst length,
// full stall, early release and reset behaviour.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        wr_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        grant_active;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  int         rem[4];
  logic [7:0] cur[4];
  logic       full_tab[64];
  logic       en_l[64];
  logic [7:0] dat_l[64];
  logic [3:0] rdy_l[64];
  logic       ga_l[64];
  logic [1:0] gid_l[64];
  logic [7:0] bc_l[64];
  logic [1:0] rr_l[64];

  fifo_wr_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .BURST_LEN(4),
    .ID_WIDTH(2)
  ) dut (
    .wr_clk(clk),
    .wr_rst(wr_rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .full(full),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .grant_active(grant_active),
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int c);
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_data[i*8 +: 8] = cur[i];
    end
    full = full_tab[c];
  endtask

  // Requester model: hold data until ready, then advance.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive(c);
      @(negedge clk);
      en_l[c]  = wr_en;
      dat_l[c] = wr_data;
      rdy_l[c] = req_ready;
      ga_l[c]  = grant_active;
      gid_l[c] = grant_id;
      bc_l[c]  = dut.beat_cnt;
      rr_l[c]  = dut.rr_ptr;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          rem[i]--;
          cur[i]++;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      cur[i] = '0;
    end
    for (int c = 0; c < 64; c++) full_tab[c] = 1'b0;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    wr_rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rem[1] = 4;
    cur[1] = 8'h11;
    run(3);
    #3;
    wr_rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_en got %b exp 0", wr_en);
    end
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL rst_ready got %h exp 0", req_ready);
    end
    checks++;
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL rst_active got %b exp 0", grant_active);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_gid got %0d exp 0", grant_id);
    end
    checks++;
    if (wr_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h exp 0", wr_data);
    end
    rem[1] = 0;
    drive(0);
    @(posedge clk);
    #1;
    wr_rst = 1'b0;
    run(3);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (en_l[c] !== 1'b0 || ga_l[c] !== 1'b0 || rdy_l[c] !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_rst c%0d en %b ga %b rdy %h exp 0",
                 c, en_l[c], ga_l[c], rdy_l[c]);
      end
    end
  endtask

  task automatic test_single_split();
    logic exp_en[10];
    logic [7:0] exp_d;
    exp_en = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    do_reset();
    rem[1] = 6;
    cur[1] = 8'h11;
    run(10);
    exp_d = 8'h11;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (en_l[c] !== exp_en[c]) begin
        errors++;
        $display("FAIL split_en c%0d got %b exp %b", c, en_l[c], exp_en[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (dat_l[c] !== exp_d || rdy_l[c] !== 4'b0010) begin
          errors++;
          $display("FAIL split_data c%0d got %h/%b exp %h/0010",
                   c, dat_l[c], rdy_l[c], exp_d);
        end
        exp_d++;
      end
    end
    checks++;
    if (gid_l[1] !== 2'd1 || gid_l[6] !== 2'd1) begin
      errors++;
      $display("FAIL split_gid got %0d,%0d exp 1,1", gid_l[1], gid_l[6]);
    end
    checks++;
    if (ga_l[5] !== 1'b0 || ga_l[9] !== 1'b0) begin
      errors++;
      $display("FAIL split_idle got %b,%b exp 0,0", ga_l[5], ga_l[9]);
    end
  endtask

  task automatic test_round_robin();
    int cnt[4];
    int g;
    logic exp_en;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 20;
      cur[i] = 8'(i * 16);
      cnt[i] = 0;
    end
    run(25);
    for (int c = 0; c < 25; c++) begin
      exp_en = (c >= 1) && (c % 5 != 0);
      checks++;
      if (en_l[c] !== exp_en) begin
        errors++;
        $display("FAIL rr_en c%0d got %b exp %b", c, en_l[c], exp_en);
      end
      if (exp_en) begin
        g = ((c - 1) / 5) % 4;
        exp_d = 8'(g * 16 + cnt[g]);
        cnt[g]++;
        checks++;
        if (dat_l[c] !== exp_d) begin
          errors++;
          $display("FAIL rr_data c%0d got %h exp %h", c, dat_l[c], exp_d);
        end
      end
      if (c % 5 == 1) begin
        exp_g = 2'(((c - 1) / 5) % 4);
        checks++;
        if (gid_l[c] !== exp_g) begin
          errors++;
          $display("FAIL rr_gid c%0d got %0d exp %0d", c, gid_l[c], exp_g);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic exp_en[10];
    logic [7:0] exp_d;
    exp_en = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
    do_reset();
    rem[0] = 4;
    cur[0] = 8'hA0;
    full_tab[3] = 1'b1;
    full_tab[4] = 1'b1;
    full_tab[5] = 1'b1;
    run(10);
    exp_d = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (en_l[c] !== exp_en[c]) begin
        errors++;
        $display("FAIL stall_en c%0d got %b exp %b", c, en_l[c], exp_en[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (dat_l[c] !== exp_d) begin
          errors++;
          $display("FAIL stall_data c%0d got %h exp %h", c, dat_l[c], exp_d);
        end
        exp_d++;
      end
    end
    for (int c = 3; c < 6; c++) begin
      checks++;
      if (rdy_l[c] !== 4'h0 || bc_l[c] !== 8'd2 || ga_l[c] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold c%0d rdy %h cnt %0d ga %b exp 0/2/1",
                 c, rdy_l[c], bc_l[c], ga_l[c]);
      end
    end
    checks++;
    if (ga_l[8] !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got %b exp 0", ga_l[8]);
    end
  endtask

  task automatic test_early_release();
    logic exp_en[8];
    logic [7:0] exp_d[8];
    exp_en = '{0, 1, 1, 0, 0, 1, 1, 1};
    exp_d  = '{8'h00, 8'h20, 8'h21, 8'h00, 8'h00, 8'h30, 8'h31, 8'h32};
    do_reset();
    rem[2] = 2;
    cur[2] = 8'h20;
    rem[3] = 4;
    cur[3] = 8'h30;
    run(8);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (en_l[c] !== exp_en[c]) begin
        errors++;
        $display("FAIL early_en c%0d got %b exp %b", c, en_l[c], exp_en[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (dat_l[c] !== exp_d[c]) begin
          errors++;
          $display("FAIL early_data c%0d got %h exp %h",
                   c, dat_l[c], exp_d[c]);
        end
      end
    end
    checks++;
    if (gid_l[1] !== 2'd2) begin
      errors++;
      $display("FAIL early_gid2 got %0d exp 2", gid_l[1]);
    end
    checks++;
    if (ga_l[4] !== 1'b0 || rr_l[4] !== 2'd3) begin
      errors++;
      $display("FAIL early_rr ga %b rr %0d exp 0/3", ga_l[4], rr_l[4]);
    end
    checks++;
    if (gid_l[5] !== 2'd3 || ga_l[5] !== 1'b1) begin
      errors++;
      $display("FAIL early_gid3 got %0d/%b exp 3/1", gid_l[5], ga_l[5]);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[3] = 8;
    cur[3] = 8'h30;
    run(3);
    checks++;
    if (en_l[1] !== 1'b1 || en_l[2] !== 1'b1 || dat_l[2] !== 8'h31) begin
      errors++;
      $display("FAIL mid_pre en %b%b data %h exp 11/31",
               en_l[1], en_l[2], dat_l[2]);
    end
    rem[0] = 4;
    cur[0] = 8'h05;
    drive(0);
    #2;
    wr_rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || grant_active !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst en %b ga %b exp 0/0", wr_en, grant_active);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || req_ready !== 4'h0) begin
        errors++;
        $display("FAIL mid_hold c%0d en %b rdy %h exp 0", c, wr_en, req_ready);
      end
    end
    @(posedge clk);
    #1;
    wr_rst = 1'b0;
    run(2);
    checks++;
    if (en_l[0] !== 1'b0 || ga_l[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle en %b ga %b exp 0/0", en_l[0], ga_l[0]);
    end
    checks++;
    if (gid_l[1] !== 2'd0 || en_l[1] !== 1'b1 || dat_l[1] !== 8'h05) begin
      errors++;
      $display("FAIL mid_regrant gid %0d en %b data %h exp 0/1/05",
               gid_l[1], en_l[1], dat_l[1]);
    end
  endtask

  initial begin
    wr_rst    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    test_reset();
    test_single_split();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
